// File: rtl/uart_tx_fifo_if.sv
// Write-bus and serializer handshake bundle for the buffered UART transmit path.
// The master side is the SoC (bus decode plus tx_uart); the slave side is the FIFO.
interface uart_tx_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (
    output wr_valid, wr_data, tx_done,
    input  wr_ready, tx_start, tx_data
  );

  modport slave (
    input  wr_valid, wr_data, tx_done,
    output wr_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit path: CPU byte writes land in a FIFO, and a drain FSM
// hands the bytes one at a time to the tx_uart serializer. It also exports LSR THRE/TEMT.
module uart_tx_fifo #(
  parameter int DEPTH    = 16,
  parameter bit BLOCKING = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  uart_tx_fifo_if.slave            bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     thre,
  output logic                     temt,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_wr_ready;
  logic            r_overflow;
  logic [7:0]      r_tx_data;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // Accept is judged on the current full flag, so a blocked write waits for
  // the cycle after a pop even though that pop frees a slot at the same edge.
  assign w_accept = bus.wr_valid && !r_wr_ready && (!w_full || !BLOCKING);
  assign w_push   = w_accept && !w_full && !flush;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !flush) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: w_next_state = S_WAIT;
      S_WAIT:  if (bus.tx_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_wr_ready <= 1'b0;
      r_overflow <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      // The ack pulses even when flush discards the byte, so the bus never hangs.
      r_wr_ready <= w_accept;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: r_level <= r_level;
        endcase
        if (w_accept && w_full) r_overflow <= 1'b1;
      end
      if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  assign bus.wr_ready = r_wr_ready;
  assign bus.tx_start = (r_state == S_START);
  assign bus.tx_data  = r_tx_data;
  assign level        = r_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign thre         = w_empty;
  assign temt         = w_empty && (r_state == S_IDLE);
  assign overflow     = r_overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a blocking instance (A) and a drop-mode instance (B)
// with cycle-exact expectations.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       flush_a, flush_b;
  logic [4:0] level_a, level_b;
  logic       full_a, full_b, empty_a, empty_b, thre_a, thre_b, temt_a, temt_b;
  logic       ovf_a, ovf_b;

  uart_tx_fifo_if if_a ();
  uart_tx_fifo_if if_b ();

  uart_tx_fifo #(.DEPTH(16), .BLOCKING(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(if_a), .flush(flush_a), .level(level_a),
    .full(full_a), .empty(empty_a), .thre(thre_a), .temt(temt_a), .overflow(ovf_a)
  );

  uart_tx_fifo #(.DEPTH(16), .BLOCKING(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(if_b), .flush(flush_b), .level(level_b),
    .full(full_b), .empty(empty_b), .thre(thre_b), .temt(temt_b), .overflow(ovf_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wb(input int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic write_byte(input bit sel, input logic [7:0] d);
    bit got;
    got = 1'b0;
    if (sel) begin if_b.wr_valid = 1'b1; if_b.wr_data = d; end
    else     begin if_a.wr_valid = 1'b1; if_a.wr_data = d; end
    for (int n = 0; n < 200; n++) begin
      tick();
      if ((sel ? if_b.wr_ready : if_a.wr_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (sel) if_b.wr_valid = 1'b0;
    else     if_a.wr_valid = 1'b0;
    chk("write_ack", 32'(got), 32'd1);
  endtask

  // tx_done in cycle M must give the next tx_start in M+2 carrying exp.
  task automatic done_then_next(input logic [7:0] exp);
    if_a.tx_done = 1'b1;
    tick();
    if_a.tx_done = 1'b0;
    chk("next_start_early", 32'(if_a.tx_start), 32'd0);
    tick();
    chk("next_start", 32'(if_a.tx_start), 32'd1);
    chk("next_data", 32'(if_a.tx_data), 32'(exp));
    tick();
    chk("data_stable", 32'(if_a.tx_data), 32'(exp));
  endtask

  initial begin
    int starts;
    resetn = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0;
    if_a.wr_valid = 1'b0; if_a.wr_data = '0; if_a.tx_done = 1'b0;
    if_b.wr_valid = 1'b0; if_b.wr_data = '0; if_b.tx_done = 1'b0;
    tick();
    tick();

    chk("rst_wr_ready", 32'(if_a.wr_ready), 32'd0);
    chk("rst_tx_start", 32'(if_a.tx_start), 32'd0);
    chk("rst_tx_data", 32'(if_a.tx_data), 32'd0);
    chk("rst_level", 32'(level_a), 32'd0);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_thre", 32'(thre_a), 32'd1);
    chk("rst_temt", 32'(temt_a), 32'd1);
    chk("rst_overflow", 32'(ovf_a), 32'd0);
    chk("rst_b_temt", 32'(temt_b), 32'd1);
    resetn = 1'b1;
    tick();

    // Single byte with exact latency
    if_a.wr_valid = 1'b1; if_a.wr_data = 8'h41;
    tick();
    chk("single_ready", 32'(if_a.wr_ready), 32'd1);
    chk("single_level1", 32'(level_a), 32'd1);
    chk("single_nostart", 32'(if_a.tx_start), 32'd0);
    if_a.wr_valid = 1'b0;
    tick();
    chk("single_start", 32'(if_a.tx_start), 32'd1);
    chk("single_data", 32'(if_a.tx_data), 32'h41);
    chk("single_level0", 32'(level_a), 32'd0);
    chk("single_ready_pulse", 32'(if_a.wr_ready), 32'd0);
    chk("single_temt_busy", 32'(temt_a), 32'd0);
    chk("single_thre", 32'(thre_a), 32'd1);
    tick();
    chk("single_start_1cyc", 32'(if_a.tx_start), 32'd0);
    chk("single_temt_wait", 32'(temt_a), 32'd0);
    if_a.tx_done = 1'b1;
    tick();
    if_a.tx_done = 1'b0;
    chk("single_temt_done", 32'(temt_a), 32'd1);

    // Burst to full: byte 0x00 is in flight, 0x01..0x10 fill all 16 entries
    for (int k = 0; k <= 16; k++) begin
      write_byte(1'b0, 8'(k));
      chk("burst_level", 32'(level_a), (k == 0) ? 32'd1 : 32'(k));
      chk("burst_full", 32'(full_a), (k == 16) ? 32'd1 : 32'd0);
      chk("burst_ovf", 32'(ovf_a), 32'd0);
    end

    // Blocking write held while full
    if_a.wr_valid = 1'b1; if_a.wr_data = 8'hAA;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("blk_hold_ready", 32'(if_a.wr_ready), 32'd0);
      chk("blk_hold_level", 32'(level_a), 32'd16);
    end
    if_a.tx_done = 1'b1;
    tick();
    if_a.tx_done = 1'b0;
    chk("blk_still_full", 32'(if_a.wr_ready), 32'd0);
    tick();
    chk("blk_pop_start", 32'(if_a.tx_start), 32'd1);
    chk("blk_pop_data", 32'(if_a.tx_data), 32'h01);
    chk("blk_pop_level", 32'(level_a), 32'd15);
    chk("blk_pop_noack", 32'(if_a.wr_ready), 32'd0);
    tick();
    chk("blk_ack", 32'(if_a.wr_ready), 32'd1);
    chk("blk_ack_level", 32'(level_a), 32'd16);
    chk("blk_ovf", 32'(ovf_a), 32'd0);
    if_a.wr_valid = 1'b0;

    for (int b = 2; b <= 16; b++) done_then_next(8'(b));
    done_then_next(8'hAA);
    if_a.tx_done = 1'b1;
    tick();
    if_a.tx_done = 1'b0;
    chk("burst_temt", 32'(temt_a), 32'd1);
    chk("burst_empty", 32'(empty_a), 32'd1);
    tick();
    chk("burst_idle", 32'(if_a.tx_start), 32'd0);

    // Simultaneous push/pop across pointer wrap
    write_byte(1'b0, wb(0));
    write_byte(1'b0, wb(1));
    write_byte(1'b0, wb(2));
    chk("wrap_prefill", 32'(level_a), 32'd2);
    for (int i = 3; i < 40; i++) begin
      if_a.tx_done = 1'b1;
      tick();
      if_a.tx_done = 1'b0;
      if_a.wr_valid = 1'b1; if_a.wr_data = wb(i);
      tick();
      chk("wrap_ack", 32'(if_a.wr_ready), 32'd1);
      chk("wrap_start", 32'(if_a.tx_start), 32'd1);
      chk("wrap_data", 32'(if_a.tx_data), 32'(wb(i - 2)));
      chk("wrap_level", 32'(level_a), 32'd2);
      if_a.wr_valid = 1'b0;
      tick();
    end

    // Flush while a byte is in WAIT, together with a write
    flush_a = 1'b1;
    if_a.wr_valid = 1'b1; if_a.wr_data = 8'h55;
    tick();
    flush_a = 1'b0;
    if_a.wr_valid = 1'b0;
    chk("flush_level", 32'(level_a), 32'd0);
    chk("flush_empty", 32'(empty_a), 32'd1);
    chk("flush_thre", 32'(thre_a), 32'd1);
    chk("flush_ack", 32'(if_a.wr_ready), 32'd1);
    chk("flush_temt_busy", 32'(temt_a), 32'd0);
    chk("flush_inflight", 32'(if_a.tx_data), 32'(wb(37)));
    tick();
    tick();
    chk("flush_nostart", 32'(if_a.tx_start), 32'd0);
    if_a.tx_done = 1'b1;
    tick();
    if_a.tx_done = 1'b0;
    chk("flush_temt", 32'(temt_a), 32'd1);
    starts = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (if_a.tx_start === 1'b1) starts++;
    end
    chk("flush_discard", 32'(starts), 32'd0);

    // Reset during WAIT with five bytes queued
    for (int k = 0; k < 6; k++) write_byte(1'b0, 8'hC0 + 8'(k));
    chk("rstw_level5", 32'(level_a), 32'd5);
    chk("rstw_temt_busy", 32'(temt_a), 32'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rstw_level", 32'(level_a), 32'd0);
    chk("rstw_empty", 32'(empty_a), 32'd1);
    chk("rstw_temt", 32'(temt_a), 32'd1);
    chk("rstw_txdata", 32'(if_a.tx_data), 32'd0);
    starts = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (if_a.tx_start === 1'b1) starts++;
    end
    chk("rstw_nostart", 32'(starts), 32'd0);
    write_byte(1'b0, 8'h5A);
    tick();
    chk("rstw_refill_start", 32'(if_a.tx_start), 32'd1);
    chk("rstw_refill_data", 32'(if_a.tx_data), 32'h5A);

    // Drop mode on instance B
    for (int k = 0; k <= 16; k++) write_byte(1'b1, 8'h20 + 8'(k));
    chk("drop_level_full", 32'(level_b), 32'd16);
    chk("drop_full", 32'(full_b), 32'd1);
    chk("drop_ovf_before", 32'(ovf_b), 32'd0);
    tick();
    if_b.wr_valid = 1'b1; if_b.wr_data = 8'hBB;
    tick();
    if_b.wr_valid = 1'b0;
    chk("drop_ack", 32'(if_b.wr_ready), 32'd1);
    chk("drop_ovf", 32'(ovf_b), 32'd1);
    chk("drop_level", 32'(level_b), 32'd16);
    tick();
    chk("drop_ovf_sticky", 32'(ovf_b), 32'd1);
    chk("drop_ack_pulse", 32'(if_b.wr_ready), 32'd0);
    flush_b = 1'b1;
    tick();
    flush_b = 1'b0;
    chk("drop_flush_ovf", 32'(ovf_b), 32'd0);
    chk("drop_flush_level", 32'(level_b), 32'd0);
    chk("drop_inflight", 32'(if_b.tx_data), 32'h20);
    if_b.tx_done = 1'b1;
    tick();
    if_b.tx_done = 1'b0;
    chk("drop_temt", 32'(temt_b), 32'd1);
    starts = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (if_b.tx_start === 1'b1) starts++;
    end
    chk("drop_never_sent", 32'(starts), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered transmit path between the SoC bus decode for UART_TX_ADDR and the tx_uart serializer.
- Accepts CPU byte writes into a DEPTH-entry FIFO and acknowledges them with the SoC's registered one-cycle ready pulse, so the CPU no longer stalls for each character.
- A drain FSM pops bytes and hands them one at a time to tx_uart via a start pulse / done pulse handshake.
- Exports 16550-style LSR status bits (THRE, TEMT) for the UART_LSR read path.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- BLOCKING, 1, 1: a write to a full FIFO is held un-acked until space frees; 0: the write is acked, the byte is dropped and overflow is set.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous reset, active-low.
- wr_valid  input  1  CPU write request, already address-decoded and gated with !wr_ready by the SoC.
- wr_data  input  8  byte to transmit (cpu_mem_wdata[7:0]).
- wr_ready  output  1  registered one-cycle write acknowledge.
- flush  input  1  synchronous FIFO clear; also clears overflow.
- tx_start  output  1  one-cycle pulse to tx_uart valid.
- tx_data  output  8  byte for tx_uart; stable from tx_start until tx_done.
- tx_done  input  1  one-cycle pulse from tx_uart ready at end of stop bit.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- thre  output  1  FIFO empty (LSR bit 5).
- temt  output  1  FIFO empty and FSM in IDLE (LSR bit 6).
- overflow  output  1  sticky; set by a dropped write.

Behaviour:
- Reset state: all outputs 0 except empty=1, thre=1, temt=1. Pointers cleared, FSM in IDLE, tx_data=0.
- Storage: DEPTH x 8 memory; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; level is a separate counter.
- Write accept condition: wr_valid && !wr_ready && (!full || !BLOCKING).
  - wr_ready <= 1 on the next edge, for exactly one cycle.
  - Push only if !full.
  - A full write with BLOCKING=0 sets overflow and is acked.
  - A full write with BLOCKING=1 leaves wr_ready at 0 while the request is held; it is accepted in the first cycle full is 0.
- Latency: write sampled in cycle N gives wr_ready high in N+1 and level incremented in N+1.
- Drain FSM:
  - IDLE: if !empty, then tx_data <= head, pop, go to START.
  - START: tx_start=1 (Moore output, exactly one cycle), go to WAIT. tx_done is ignored in START.
  - WAIT: on tx_done, go to IDLE.
- Drain timing:
  - A byte written into an empty FIFO in cycle N produces tx_start in cycle N+2.
  - Back-to-back bytes: tx_done in cycle M gives the next tx_start in cycle M+2.
- Simultaneous push and pop: level unchanged. The pointers each advance. The full-FIFO case is legal (the pop frees the slot at the same edge as the push, but accept is evaluated on the current full, so a BLOCKING write waits one cycle).
- flush:
  - Clears pointers, level and overflow.
  - Does not abort the byte in START/WAIT; that byte completes, so temt stays 0 until WAIT exits.
  - flush with a same-cycle write: flush wins and the byte is discarded, but wr_ready is still pulsed (no bus hang).
- Reset mid-operation (any state): return to reset values next edge. No tx_start is emitted until the FIFO is refilled.
- Status outputs full, empty, thre, temt and level are registered-derived (from level/state), with no combinational path from wr_valid.

Test Plan:
- Single byte: write 0x41 in cycle 10 -> wr_ready in cycle 11, tx_start in cycle 12 with tx_data=0x41; level 1->0 at 12; temt=0 until tx_done+1, then temt=1.
- Burst ordering: 16 writes 0x00..0x0F with tx_done every 100 cycles -> tx_data sequence 0x00..0x0F in order; full=1 exactly when level=16; no overflow.
- Blocking full (BLOCKING=1): fill 16 bytes, hold write 0xAA -> wr_ready stays 0 until the first pop; then ack; 0xAA is transmitted 17th.
- Drop mode (BLOCKING=0): fill 16 bytes, write 0xBB -> wr_ready after 1 cycle, overflow=1, level stays 16, 0xBB never transmitted; flush -> overflow=0, level=0.
- Pointer wrap / simultaneous: 40 bytes with writes coinciding with IDLE pops -> level never exceeds the expected value, and all 40 bytes come out in order across the pointer wrap.
- Reset during WAIT with 5 bytes queued -> next cycle level=0, empty=1, temt=1; no tx_start is emitted after reset until a new write.
